wdt_window: RTL and testbench
=============================

# wdt_window

Parametrised windowed watchdog timer with a pre-timeout warning, early-kick fault detection, runtime configuration with write lock, and a fixed-length reset-request pulse. Sits beside the system controller. Software or a supervisor FSM services it with `kick`. Its `wdt_rst` output feeds the reset generator.

## Interface
Parameters:
- `CNT_W`, 16: counter and config field width.
- `DEF_TIMEOUT`, 100: reset value of the timeout register.
- `DEF_WINDOW`, 20: reset value of the window register (earliest legal kick count).
- `DEF_WARN`, 10: reset value of the warning margin.
- `RST_PULSE_LEN`, 4: `wdt_rst` pulse length in cycles, at least 1.

Ports:
- `clk`, in, 1: sole clock; all logic on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: watchdog enable.
- `kick`, in, 1: service strobe, sampled each cycle.
- `cfg_we`, in, 1: config write strobe.
- `cfg_timeout`, in, CNT_W: timeout count.
- `cfg_window`, in, CNT_W: window count.
- `cfg_warn`, in, CNT_W: warning margin.
- `lock`, in, 1: sets the sticky config lock.
- `cnt`, out, CNT_W: current count.
- `state`, out, 2: 0 IDLE, 1 RUN, 2 EXPIRED.
- `warn`, out, 1: pre-timeout warning.
- `timeout`, out, 1: expiry flag, sticky.
- `early_kick`, out, 1: window-violation flag, sticky.
- `wdt_rst`, out, 1: reset-request pulse.
- `cfg_err`, out, 1: one-cycle pulse when a config write is rejected.

## Operation
- Reset (`rst_n`=0):
  - State goes to IDLE; `cnt`=0.
  - `warn`, `timeout`, `early_kick`, `wdt_rst`, `cfg_err` and lock go to 0.
  - Config registers load the DEF_* values.
- Config write (`cfg_we`=1):
  - Accepted only in IDLE with lock=0, and only when `cfg_warn < cfg_timeout`, `cfg_window < cfg_timeout` and `cfg_timeout != 0`.
  - All three registers update together on the next edge.
  - Any other write leaves the registers unchanged and pulses `cfg_err` for one cycle.
- `lock`=1 sets the lock, which clears only on reset.
- IDLE:
  - `cnt` holds 0 and `kick` is ignored.
  - `en`=1 moves to RUN on the next edge; `cnt` starts at 0.
- RUN: let TO, WIN and WRN be the register values. All compares use the current registered `cnt`.
  - `en`=0 → IDLE, `cnt`←0, `warn`←0.
  - Else, `kick` with `cnt` ≥ WIN → `cnt`←0 (valid service).
  - Else, `kick` with `cnt` < WIN → EXPIRED, `early_kick`←1.
  - Else, `cnt` == TO → EXPIRED, `timeout`←1.
  - Else `cnt`←`cnt`+1. No wrap is possible because TO ≤ 2^CNT_W−1.
  - Priority is `en` > kick > expiry, so a valid kick at `cnt`==TO services the watchdog.
- `warn` is a combinational decode of registered state: state==RUN and `cnt` ≥ TO−WRN.
- EXPIRED:
  - `cnt` freezes and `kick` is ignored.
  - `wdt_rst`=1 for exactly RST_PULSE_LEN cycles starting on the entry cycle, then 0.
  - `timeout` and `early_kick` hold.
  - `en`=0 → IDLE, which clears `timeout`, `early_kick` and `wdt_rst`, including mid-pulse.
- `rst_n` asserted in any state, including mid-pulse, immediately forces the reset values.

## Timing
- Enable latency: `en` rises in cycle e; RUN in e+1 with `cnt`=0.
- Timeout latency:
  - Valid kick in cycle k → `cnt`=0 at k+1 and `cnt`=TO at k+1+TO.
  - `timeout`=1, state=EXPIRED and `wdt_rst`=1 at k+2+TO.
- Early-kick fault is flagged one cycle after the offending kick.
- `warn` rises in the same cycle `cnt` first equals TO−WRN.
- `cfg_err` is high in the cycle after the rejected write.
- Accepted config values are used from the following cycle.

## Test plan
- Defaults, `en`=1, no kicks:
  - `warn` rises when `cnt`=90.
  - `timeout`=1 and state=2 one cycle after `cnt`=100.
  - `wdt_rst` is high for exactly 4 cycles, then 0; `timeout` stays 1.
- Defaults, kick every 50 cycles for 1000 cycles:
  - `timeout`, `early_kick` and `wdt_rst` never assert.
  - `cnt` returns to 0 the cycle after each kick.
- Early kick: kick at `cnt`=5 → `early_kick`=1, state=2 and `wdt_rst` pulses 4 cycles. Kick at `cnt`=20 → accepted.
- Boundaries:
  - Kick exactly at `cnt`=100 → `cnt`=0 and no timeout.
  - Kick at `cnt`=19 → early fault.
- Config in IDLE:
  - Write TO=30, WIN=5, WRN=3 → timeout one cycle after `cnt`=30.
  - Write with WIN=40, TO=30 → `cfg_err` pulse and values unchanged.
  - Write after `lock`=1 → `cfg_err` pulse.
  - Write while in RUN → `cfg_err` pulse.
- Clear paths:
  - `en`=0 during the `wdt_rst` pulse (cycle 2 of 4) → IDLE next cycle with all flags 0.
  - `rst_n` low mid-RUN → all outputs 0 immediately and config back to 100/20/10.

Source files
------------

// File: rtl/wdt_window_if.sv
// Configuration bus for wdt_window.
// The master side (software / supervisor) drives the write strobe, the
// three config fields and the lock request. The slave side (the watchdog)
// returns the one-cycle rejected-write pulse.
//   cfg_we      : config write strobe
//   cfg_timeout : timeout count
//   cfg_window  : earliest legal kick count
//   cfg_warn    : warning margin below timeout
//   lock        : sets the sticky config lock
//   cfg_err     : pulses for one cycle after a rejected write
interface wdt_window_if #(
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_timeout;
  logic [CNT_W-1:0] cfg_window;
  logic [CNT_W-1:0] cfg_warn;
  logic             lock;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_timeout, cfg_window, cfg_warn, lock,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_timeout, cfg_window, cfg_warn, lock,
    output cfg_err
  );
endinterface

// File: rtl/wdt_window.sv
// Windowed watchdog timer with pre-timeout warning, early-kick detection,
// lockable runtime configuration and a fixed-length reset-request pulse.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : watchdog enable
//   kick       : service strobe
//   cfg        : configuration bus (slave side)
//   cnt        : current count
//   state      : 0 IDLE, 1 RUN, 2 EXPIRED
//   warn       : pre-timeout warning
//   timeout    : sticky expiry flag
//   early_kick : sticky window-violation flag
//   wdt_rst    : reset-request pulse, RST_PULSE_LEN cycles
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | disabled, cnt held at 0, config writes allowed
// RUN     | counting up, kicks serviced or flagged as early
// EXPIRED | count frozen, reset pulse issued, flags held until en=0
module wdt_window #(
  parameter int CNT_W         = 16,
  parameter int DEF_TIMEOUT   = 100,
  parameter int DEF_WINDOW    = 20,
  parameter int DEF_WARN      = 10,
  parameter int RST_PULSE_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             kick,
  wdt_window_if.slave      cfg,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state,
  output logic             warn,
  output logic             timeout,
  output logic             early_kick,
  output logic             wdt_rst
);

  localparam int PW = $clog2(RST_PULSE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] to_q, win_q, wrn_q;
  logic             lock_q, cfg_err_q;
  logic             timeout_q, timeout_d;
  logic             early_q, early_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic             cfg_ok;

  assign cfg_ok = cfg.cfg_we && (state_q == IDLE) && !lock_q &&
                  (cfg.cfg_warn < cfg.cfg_timeout) &&
                  (cfg.cfg_window < cfg.cfg_timeout) &&
                  (cfg.cfg_timeout != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q      <= CNT_W'(DEF_TIMEOUT);
      win_q     <= CNT_W'(DEF_WINDOW);
      wrn_q     <= CNT_W'(DEF_WARN);
      lock_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      if (cfg_ok) begin
        to_q  <= cfg.cfg_timeout;
        win_q <= cfg.cfg_window;
        wrn_q <= cfg.cfg_warn;
      end
      cfg_err_q <= cfg.cfg_we && !cfg_ok;
      lock_q    <= lock_q | cfg.lock;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
      pulse_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
      pulse_q   <= pulse_d;
    end
  end

  // Priority in RUN: en, then kick, then expiry. A valid kick at cnt==TO
  // therefore services the watchdog instead of expiring.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    early_d   = early_q;
    pulse_d   = pulse_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (kick && (cnt_q >= win_q)) begin
          cnt_d = '0;
        end else if (kick) begin
          state_d = EXPIRED;
          early_d = 1'b1;
          pulse_d = PW'(RST_PULSE_LEN);
        end else if (cnt_q == to_q) begin
          state_d   = EXPIRED;
          timeout_d = 1'b1;
          pulse_d   = PW'(RST_PULSE_LEN);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXPIRED: begin
        if (!en) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b0;
          early_d   = 1'b0;
          pulse_d   = '0;
        end else if (pulse_q != '0) begin
          pulse_d = pulse_q - PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The pulse down-counter is loaded on entry, so wdt_rst is already high
  // in the first EXPIRED cycle and drops when the counter reaches zero.
  assign wdt_rst     = (state_q == EXPIRED) && (pulse_q != '0);
  assign warn        = (state_q == RUN) && (cnt_q >= (to_q - wrn_q));
  assign cnt         = cnt_q;
  assign state       = state_q;
  assign timeout     = timeout_q;
  assign early_kick  = early_q;
  assign cfg.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_wdt_window.sv
module tb_wdt_window;
  localparam int CNT_W = 16;
  localparam int LEN   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             kick = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic             warn, timeout, early_kick, wdt_rst;

  wdt_window_if #(.CNT_W(CNT_W)) cfg_bus ();

  wdt_window #(
    .CNT_W(CNT_W), .DEF_TIMEOUT(100), .DEF_WINDOW(20), .DEF_WARN(10),
    .RST_PULSE_LEN(LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .kick(kick), .cfg(cfg_bus),
    .cnt(cnt), .state(state), .warn(warn), .timeout(timeout),
    .early_kick(early_kick), .wdt_rst(wdt_rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer state, time-since-expiry instead of a pulse counter
  int m_state, m_cnt, m_to, m_win, m_wrn, m_age;
  bit m_lock, m_timeout, m_early, m_cfgerr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_to = 100; m_win = 20; m_wrn = 10; m_age = 0;
      m_lock = 0; m_timeout = 0; m_early = 0; m_cfgerr = 0;
    end else begin
      int nst, nc, nage;
      bit nt, ne, accept;
      accept = cfg_bus.cfg_we && m_state == 0 && !m_lock &&
               int'(cfg_bus.cfg_warn) < int'(cfg_bus.cfg_timeout) &&
               int'(cfg_bus.cfg_window) < int'(cfg_bus.cfg_timeout) &&
               cfg_bus.cfg_timeout != 0;
      nst = m_state; nc = m_cnt; nage = m_age; nt = m_timeout; ne = m_early;
      if (m_state == 0) begin
        nc = 0;
        if (en) nst = 1;
      end else if (m_state == 1) begin
        if (!en) begin nst = 0; nc = 0; end
        else if (kick && m_cnt >= m_win) nc = 0;
        else if (kick) begin nst = 2; ne = 1; nage = 0; end
        else if (m_cnt == m_to) begin nst = 2; nt = 1; nage = 0; end
        else nc = m_cnt + 1;
      end else begin
        if (!en) begin nst = 0; nc = 0; nt = 0; ne = 0; end
        else if (m_age < 1000) nage = m_age + 1;
      end
      if (accept) begin
        m_to = int'(cfg_bus.cfg_timeout);
        m_win = int'(cfg_bus.cfg_window);
        m_wrn = int'(cfg_bus.cfg_warn);
      end
      m_cfgerr = cfg_bus.cfg_we && !accept;
      if (cfg_bus.lock) m_lock = 1;
      m_state = nst; m_cnt = nc; m_age = nage; m_timeout = nt; m_early = ne;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cnt", cnt, m_cnt);
      check("state", state, m_state);
      check("warn", warn, (m_state == 1 && m_cnt >= m_to - m_wrn));
      check("timeout", timeout, m_timeout);
      check("early_kick", early_kick, m_early);
      check("wdt_rst", wdt_rst, (m_state == 2 && m_age < LEN));
      check("cfg_err", cfg_bus.cfg_err, m_cfgerr);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(int v, string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (cnt == v) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s: cnt never reached %0d", name, v);
    end
  endtask

  // Returns at the first EXPIRED cycle; warn_cnt is cnt when warn first rose.
  task automatic run_to_expiry(string name, output int warn_cnt);
    bit ok = 0;
    warn_cnt = -1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (warn && warn_cnt < 0) warn_cnt = int'(cnt);
      if (state == 2) ok = 1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s: never expired", name);
    end
  endtask

  task automatic count_pulse(string name);
    int hi = 0;
    hi += int'(wdt_rst);
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      hi += int'(wdt_rst);
    end
    check(name, hi, LEN);
  endtask

  task automatic cfg_write(int to, int win, int wrn);
    cfg_bus.cfg_timeout = CNT_W'(to);
    cfg_bus.cfg_window  = CNT_W'(win);
    cfg_bus.cfg_warn    = CNT_W'(wrn);
    cfg_bus.cfg_we      = 1'b1;
    cyc(1);
    cfg_bus.cfg_we      = 1'b0;
  endtask

  initial begin
    int wc;
    int rst_seen;
    cfg_bus.cfg_we = 0; cfg_bus.lock = 0;
    cfg_bus.cfg_timeout = '0; cfg_bus.cfg_window = '0; cfg_bus.cfg_warn = '0;
    cyc(3);
    check("rst_cnt", cnt, 0);
    check("rst_state", state, 0);
    check("rst_flags", {warn, timeout, early_kick, wdt_rst, cfg_bus.cfg_err}, 0);
    rst_seen = 0;
    rst_n = 1;
    cmp_on = 1;

    // Defaults, no kicks
    en = 1;
    run_to_expiry("to_default", wc);
    check("warn_at_90", wc, 90);
    check("expire_cnt_100", cnt, 100);
    check("expire_timeout", timeout, 1);
    count_pulse("pulse_len_timeout");
    check("timeout_sticky", timeout, 1);
    en = 0; cyc(1);
    check("idle_after_en0", state, 0);

    // Periodic kicks every 50 cycles
    en = 1;
    for (int i = 0; i < 1000; i++) begin
      kick = (i % 50 == 49);
      cyc(1);
      if (kick) check("kick_cnt0", cnt, 0);
      rst_seen += int'(wdt_rst | timeout | early_kick);
    end
    kick = 0;
    check("periodic_no_fault", rst_seen, 0);

    // Early kick at 5, then valid kick at 20
    en = 0; cyc(1); en = 1;
    wait_cnt(5, "early5");
    kick = 1; cyc(1); kick = 0;
    check("early_flag", early_kick, 1);
    check("early_state", state, 2);
    count_pulse("pulse_len_early");
    en = 0; cyc(1); en = 1;
    wait_cnt(20, "win20");
    kick = 1; cyc(1); kick = 0;
    check("kick20_cnt", cnt, 0);
    check("kick20_state", state, 1);

    // Kick exactly at TO, then at 19
    wait_cnt(100, "cnt100");
    kick = 1; cyc(1); kick = 0;
    check("kick_at_to_cnt", cnt, 0);
    check("kick_at_to_noto", timeout, 0);
    wait_cnt(19, "cnt19");
    kick = 1; cyc(1); kick = 0;
    check("kick19_early", early_kick, 1);

    // Config in IDLE
    en = 0; cyc(1);
    cfg_write(30, 5, 3);
    check("cfg_ok_noerr", cfg_bus.cfg_err, 0);
    en = 1;
    run_to_expiry("to30", wc);
    check("to30_cnt", cnt, 30);
    check("to30_warn", wc, 27);
    en = 0; cyc(1);
    cfg_write(30, 40, 3);
    check("cfg_bad_err", cfg_bus.cfg_err, 1);
    cyc(1);
    check("cfg_err_one_cycle", cfg_bus.cfg_err, 0);
    en = 1;
    run_to_expiry("to30_kept", wc);
    check("to30_kept_cnt", cnt, 30);
    en = 0; cyc(1);
    en = 1; cyc(3);
    cfg_write(50, 5, 3);
    check("cfg_run_err", cfg_bus.cfg_err, 1);
    en = 0; cyc(1);
    cfg_bus.lock = 1; cyc(1); cfg_bus.lock = 0;
    cfg_write(50, 5, 3);
    check("cfg_lock_err", cfg_bus.cfg_err, 1);

    // en=0 in pulse cycle 2
    en = 1;
    run_to_expiry("clr_pulse", wc);
    check("clr_entry_rst", wdt_rst, 1);
    cyc(1);
    en = 0; cyc(1);
    check("clr_state", state, 0);
    check("clr_flags", {timeout, early_kick, wdt_rst}, 0);

    // Async reset mid-RUN
    en = 1; cyc(10);
    @(posedge clk); #2 rst_n = 0; #1;
    check("arst_cnt", cnt, 0);
    check("arst_state", state, 0);
    check("arst_flags", {warn, timeout, early_kick, wdt_rst, cfg_bus.cfg_err}, 0);
    cyc(2); rst_n = 1;
    run_to_expiry("post_rst", wc);
    check("post_rst_to", cnt, 100);
    check("post_rst_warn", wc, 90);
    en = 0; cyc(1);
    cfg_write(40, 5, 3);
    check("post_rst_unlocked", cfg_bus.cfg_err, 0);
    cyc(2);

    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
